// File: rtl/chiptune_poly.sv
// -----------------------------------------------------------------------------
// chiptune_poly : multi-voice square-wave synthesiser driven by 8N1 serial
// command packets.
//
// A 4-byte packet (HDR, LO, HI, VOL) sets one voice's 12-bit half-period and
// 4-bit volume. The active voices are summed and played as a single PWM output.
//
// Ports:
//   clk       in   system clock (CLKRATE Hz)
//   rst_n     in   asynchronous active-low reset
//   rx        in   serial data, idle high, asynchronous to clk
//   pwm       out  mixed audio PWM
//   blink     out  heartbeat LED, toggles every CLKRATE/2 clocks
//   link      out  serial activity LED, held LINK_HOLD clocks after a good byte
//   frame_err out  one-clock pulse when a stop bit samples low
//
// Optional build macro:
//   CHIPTUNE_NOISE_EN  voice NUM_CH-1 plays 15-bit Galois LFSR noise instead of
//                      a square wave
// -----------------------------------------------------------------------------
module chiptune_poly #(
   parameter int CLKRATE   = 12_000_000,
   parameter int BAUDRATE  = 9600,
   parameter int NUM_CH    = 4,
   parameter int TONE_DIV  = 12,
   parameter int LINK_HOLD = 600_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic pwm,
   output logic blink,
   output logic link,
   output logic frame_err
);

   localparam int BAUD_DIV  = CLKRATE / BAUDRATE;
   localparam int HALF_DIV  = BAUD_DIV / 2;
   localparam int BW        = $clog2(BAUD_DIV + 1);
   localparam int TW        = $clog2(TONE_DIV + 1);
   localparam int LW        = $clog2(LINK_HOLD + 1);
   localparam int BLINK_DIV = CLKRATE / 2;
   localparam int KW        = $clog2(BLINK_DIV + 1);
   localparam int SW        = 4 + $clog2(NUM_CH);

   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_st_t;
   typedef enum logic [1:0] {P_WAIT_HDR, P_WAIT_LO, P_WAIT_HI, P_WAIT_VOL} pars_st_t;

   // ---------------------------------------------------------------- UART rx
   logic           r_rx_meta;
   logic           r_rx_sync;
   logic           r_rx_prev;
   uart_st_t       r_ust;
   logic [BW-1:0]  r_bcnt;
   logic [2:0]     r_bit_idx;
   logic [7:0]     r_shift;
   logic           r_byte_valid;
   logic           r_frame_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta    <= 1'b1;
         r_rx_sync    <= 1'b1;
         r_rx_prev    <= 1'b1;
         r_ust        <= U_IDLE;
         r_bcnt       <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_meta    <= rx;
         r_rx_sync    <= r_rx_meta;
         r_rx_prev    <= r_rx_sync;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_ust)
            U_IDLE: begin
               r_bcnt <= '0;
               // A falling edge is required, so a line stuck low after a
               // framing error does not retrigger reception.
               if (r_rx_prev && !r_rx_sync) r_ust <= U_START;
            end
            U_START: begin
               if (r_bcnt == BW'(HALF_DIV - 1)) begin
                  r_bcnt    <= '0;
                  r_bit_idx <= '0;
                  r_ust     <= r_rx_sync ? U_IDLE : U_DATA;
               end else begin
                  r_bcnt <= r_bcnt + 1'b1;
               end
            end
            U_DATA: begin
               if (r_bcnt == BW'(BAUD_DIV - 1)) begin
                  r_bcnt    <= '0;
                  r_shift   <= {r_rx_sync, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) r_ust <= U_STOP;
               end else begin
                  r_bcnt <= r_bcnt + 1'b1;
               end
            end
            U_STOP: begin
               if (r_bcnt == BW'(BAUD_DIV - 1)) begin
                  r_bcnt <= '0;
                  if (r_rx_sync) r_byte_valid <= 1'b1;
                  else           r_frame_err  <= 1'b1;
                  r_ust <= U_IDLE;
               end else begin
                  r_bcnt <= r_bcnt + 1'b1;
               end
            end
            default: r_ust <= U_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------- packet parser
   pars_st_t                    r_pst;
   logic [2:0]                  r_ch;
   logic [6:0]                  r_plo;
   logic [4:0]                  r_phi;
   logic [NUM_CH-1:0][11:0]     r_period;
   logic [NUM_CH-1:0][3:0]      r_volume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pst    <= P_WAIT_HDR;
         r_ch     <= '0;
         r_plo    <= '0;
         r_phi    <= '0;
         r_period <= '0;
         r_volume <= '0;
      end else if (r_byte_valid) begin
         if (r_shift[7]) begin
            r_ch  <= r_shift[2:0];
            r_pst <= P_WAIT_LO;
         end else begin
            case (r_pst)
               P_WAIT_LO: begin
                  r_plo <= r_shift[6:0];
                  r_pst <= P_WAIT_HI;
               end
               P_WAIT_HI: begin
                  r_phi <= r_shift[4:0];
                  r_pst <= P_WAIT_VOL;
               end
               P_WAIT_VOL: begin
                  // Matching by loop skips channels >= NUM_CH naturally.
                  for (int unsigned c = 0; c < NUM_CH; c++) begin
                     if (r_ch == 3'(c)) begin
                        r_period[c] <= {r_phi, r_plo};
                        r_volume[c] <= r_shift[3:0];
                     end
                  end
                  r_pst <= P_WAIT_HDR;
               end
               default: r_pst <= P_WAIT_HDR;
            endcase
         end
      end
   end

   // -------------------------------------------------------- tone generation
   logic [TW-1:0]           r_pre;
   logic                    w_tick;
   logic [NUM_CH-1:0][11:0] r_cnt;
   logic [NUM_CH-1:0]       r_square;

   assign w_tick = (r_pre == TW'(TONE_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pre <= '0;
      else if (w_tick) r_pre <= '0;
      else             r_pre <= r_pre + 1'b1;
   end

`ifdef CHIPTUNE_NOISE_EN
   logic [14:0] r_lfsr;
   logic [14:0] w_lfsr_next;

   // Right-shifting Galois form of the x^15 + x^14 + 1 polynomial.
   assign w_lfsr_next = {1'b0, r_lfsr[14:1]} ^ (r_lfsr[0] ? 15'h6000 : 15'h0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_lfsr <= 15'h0001;
      else if (r_period[NUM_CH-1] != '0 && w_tick && r_cnt[NUM_CH-1] == '0)
         r_lfsr <= w_lfsr_next;
   end
`endif

   // Reads of r_period here see the pre-commit value in a commit clock, so a
   // coincident reload uses the old period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_square <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (r_period[c] == '0) begin
               r_cnt[c]    <= '0;
               r_square[c] <= 1'b0;
            end else if (w_tick) begin
               if (r_cnt[c] == '0) begin
                  r_cnt[c] <= r_period[c];
`ifdef CHIPTUNE_NOISE_EN
                  if (c == NUM_CH - 1) r_square[c] <= w_lfsr_next[0];
                  else                 r_square[c] <= ~r_square[c];
`else
                  r_square[c] <= ~r_square[c];
`endif
               end else begin
                  r_cnt[c] <= r_cnt[c] - 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------ mixer
   logic [SW-1:0] w_sum;
   logic [SW-1:0] r_pwm_cnt;
   logic [SW-1:0] r_latched_sum;
   logic          r_pwm;

   always_comb begin
      w_sum = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (r_square[c]) w_sum = w_sum + SW'(r_volume[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt     <= '0;
         r_latched_sum <= '0;
         r_pwm         <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (r_pwm_cnt == '1) r_latched_sum <= w_sum;
         r_pwm <= (r_pwm_cnt < r_latched_sum);
      end
   end

   // ------------------------------------------------------------------- LEDs
   logic          r_link;
   logic [LW-1:0] r_link_cnt;
   logic          r_blink;
   logic [KW-1:0] r_blink_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_link     <= 1'b0;
         r_link_cnt <= '0;
      end else if (r_byte_valid) begin
         r_link     <= 1'b1;
         r_link_cnt <= LW'(LINK_HOLD - 1);
      end else if (r_link) begin
         if (r_link_cnt == '0) r_link     <= 1'b0;
         else                  r_link_cnt <= r_link_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink     <= 1'b0;
         r_blink_cnt <= '0;
      end else if (r_blink_cnt == KW'(BLINK_DIV - 1)) begin
         r_blink     <= ~r_blink;
         r_blink_cnt <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign pwm       = r_pwm;
   assign blink     = r_blink;
   assign link      = r_link;
   assign frame_err = r_frame_err;

endmodule
